// File: rtl/ac97_wave_gen.sv
// ac97_wave_gen
//   Sample source for the AC-link frame builder. Emits one 20-bit PCM sample per
//   AC'97 frame: square, sawtooth or triangle, with a step-selectable pitch.
//   Samples always carry two zero MSBs and feed slots 3/4.
//
// Ports
//   BIT_CLK       in   1         AC'97 bit clock, sole clock
//   reset         in   1         synchronous, active-high reset
//   frame         in   1         1-cycle strobe, once per 256-bit frame
//   wave_sel      in   3         001 square, 010 sawtooth, 100 triangle, other = silence
//   freq_up       in   1         pulse: pitch index -1 (shorter period), saturates at 1
//   freq_dn       in   1         pulse: pitch index +1 (longer period), saturates at 20
//   sample        out  SAMPLE_W  current sample, {2'b00, mag[17:0]}
//   sample_valid  out  1         1-cycle pulse when sample updates
//   period        out  11        active period in frames
//   freq_idx      out  5         active pitch index, 1..20

module ac97_wave_gen #(
    parameter int SAMPLE_W    = 20,
    parameter int AMP_BITS    = 18,
    parameter int DEFAULT_IDX = 10
) (
    input  logic                BIT_CLK,
    input  logic                reset,
    input  logic                frame,
    input  logic [2:0]          wave_sel,
    input  logic                freq_up,
    input  logic                freq_dn,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [10:0]         period,
    output logic [4:0]          freq_idx
);

    localparam int                ACC_W   = 20;
    localparam logic [ACC_W-1:0]  AMP_MAX = ACC_W'((1 << AMP_BITS) - 1);
    localparam logic [4:0]        IDX_MIN = 5'd1;
    localparam logic [4:0]        IDX_MAX = 5'd20;

    localparam logic [2:0] WAVE_SQUARE = 3'b001;
    localparam logic [2:0] WAVE_SAW    = 3'b010;
    localparam logic [2:0] WAVE_TRI    = 3'b100;

    // Period in frames for each pitch index.
    function automatic logic [10:0] periodOf(input logic [4:0] idx);
        case (idx)
            5'd1:    return 11'd2;
            5'd2:    return 11'd4;
            5'd3:    return 11'd6;
            5'd4:    return 11'd8;
            5'd5:    return 11'd10;
            5'd6:    return 11'd12;
            5'd7:    return 11'd14;
            5'd8:    return 11'd20;
            5'd9:    return 11'd24;
            5'd10:   return 11'd32;
            5'd11:   return 11'd40;
            5'd12:   return 11'd54;
            5'd13:   return 11'd70;
            5'd14:   return 11'd90;
            5'd15:   return 11'd118;
            5'd16:   return 11'd154;
            5'd17:   return 11'd200;
            5'd18:   return 11'd260;
            5'd19:   return 11'd338;
            5'd20:   return 11'd438;
            default: return 11'd32;
        endcase
    endfunction

    // floor(AMP_MAX / period), precomputed so no divider is built.
    function automatic logic [17:0] stepOf(input logic [4:0] idx);
        case (idx)
            5'd1:    return 18'd131071;
            5'd2:    return 18'd65535;
            5'd3:    return 18'd43690;
            5'd4:    return 18'd32767;
            5'd5:    return 18'd26214;
            5'd6:    return 18'd21845;
            5'd7:    return 18'd18724;
            5'd8:    return 18'd13107;
            5'd9:    return 18'd10922;
            5'd10:   return 18'd8191;
            5'd11:   return 18'd6553;
            5'd12:   return 18'd4854;
            5'd13:   return 18'd3744;
            5'd14:   return 18'd2912;
            5'd15:   return 18'd2221;
            5'd16:   return 18'd1702;
            5'd17:   return 18'd1310;
            5'd18:   return 18'd1008;
            5'd19:   return 18'd775;
            5'd20:   return 18'd598;
            default: return 18'd8191;
        endcase
    endfunction

    logic [2:0]          waveQ;
    logic [10:0]         phase;
    logic [ACC_W-1:0]    acc;
    logic                clearPend;   // pitch changed since the last frame strobe

    logic [4:0]          idxNext;
    logic                pitchChange;
    logic [10:0]         perNow;
    logic [10:0]         halfNow;
    logic [ACC_W-1:0]    step1;
    logic [ACC_W-1:0]    step2;
    logic                restart;
    logic [10:0]         phaseEff;
    logic                wrap;
    logic [10:0]         phaseNext;
    logic [ACC_W-1:0]    accEff;
    logic [ACC_W-1:0]    accNew;
    logic [ACC_W-1:0]    sum;
    logic [AMP_BITS-1:0] mag;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        idxNext = freq_idx;
        if (freq_up && !freq_dn && freq_idx > IDX_MIN)
            idxNext = freq_idx - 5'd1;
        else if (freq_dn && !freq_up && freq_idx < IDX_MAX)
            idxNext = freq_idx + 5'd1;
    end

    // A pitch pulse coinciding with a frame strobe is used by that frame.
    assign pitchChange = (idxNext != freq_idx);
    assign perNow      = periodOf(idxNext);
    assign halfNow     = perNow >> 1;
    assign step1       = ACC_W'(stepOf(idxNext));
    assign step2       = step1 << 1;

    // Any waveform or pitch change restarts the cycle from phase 0 / acc 0.
    assign restart   = (wave_sel != waveQ) || clearPend || pitchChange;
    assign phaseEff  = (restart || phase >= perNow) ? '0 : phase;
    assign wrap      = (phaseEff == perNow - 11'd1);
    assign phaseNext = wrap ? '0 : phaseEff + 11'd1;
    assign accEff    = restart ? '0 : acc;

    // acc stays <= AMP_MAX, so acc + 2*step fits in 20 bits before clamping.
    always_comb begin
        accNew = '0;
        sum    = '0;
        mag    = '0;
        case (wave_sel)
            WAVE_SQUARE: begin
                mag = (phaseEff < halfNow) ? AMP_MAX[AMP_BITS-1:0] : '0;
            end
            WAVE_SAW: begin
                if (!wrap) begin
                    sum    = accEff + step1;
                    accNew = (sum > AMP_MAX) ? AMP_MAX : sum;
                end
                mag = accNew[AMP_BITS-1:0];
            end
            WAVE_TRI: begin
                if (!wrap) begin
                    if (phaseEff < halfNow) begin
                        sum    = accEff + step2;
                        accNew = (sum > AMP_MAX) ? AMP_MAX : sum;
                    end else begin
                        accNew = (accEff > step2) ? accEff - step2 : '0;
                    end
                end
                mag = accNew[AMP_BITS-1:0];
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge BIT_CLK) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            phase        <= '0;
            acc          <= '0;
            waveQ        <= '0;
            clearPend    <= 1'b0;
            freq_idx     <= 5'(DEFAULT_IDX);
            period       <= periodOf(5'(DEFAULT_IDX));
        end else begin
            sample_valid <= frame;
            freq_idx     <= idxNext;
            period       <= perNow;
            if (frame) begin
                waveQ     <= wave_sel;
                phase     <= phaseNext;
                acc       <= accNew;
                sample    <= SAMPLE_W'(mag);
                clearPend <= 1'b0;
            end else if (pitchChange) begin
                clearPend <= 1'b1;
            end
        end
    end

endmodule
